mux_pipe_n: RTL and testbench
=============================

# mux_pipe_n

Parametrised N-way, WIDTH-bit operand select with a registered output stage and a valid/ready handshake, replacing the plain 2:1 32-bit selects at pipeline boundaries (IF next-PC, ID immediate/register operand, forwarding). A two-entry skid buffer keeps `in_ready` a function of registered state only, so stalls never create a combinational ready path between stages. An out-of-range select is flagged per entry instead of silently choosing an input. `flush` discards all buffered entries for branch or exception recovery.

## Interface
- `WIDTH`, 32, data width per input
- `N`, 4, number of inputs, 2..16
- `SELW`, `$clog2(N)`, select width; localparam, not overridable
- `clk`  in  1  clock; all logic on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_data`  in  N*WIDTH  flattened inputs; input k is bits [k*WIDTH +: WIDTH]
- `in_sel`  in  SELW  index of the input to capture
- `in_valid`  in  1  upstream offers `in_data`/`in_sel`
- `in_ready`  out  1  block can accept this cycle
- `flush`  in  1  discard all held entries
- `out_data`  out  WIDTH  selected word at the head
- `out_err`  out  1  head entry had `in_sel` >= N
- `out_valid`  out  1  head entry present
- `out_ready`  in  1  downstream takes the head this cycle

## Operation
- Accept = `in_valid & in_ready`. Emit = `out_valid & out_ready`.
- On accept, capture {word of input `in_sel`, err}. If `in_sel` >= N, capture word 0 and err 1. Otherwise capture err 0.
- Storage is a main register (head, drives `out_*`) plus a skid register.
- The state is one of EMPTY, ONE or FULL:
  - EMPTY: on accept, load main and go to ONE.
  - ONE, accept and emit: load main and stay in ONE.
  - ONE, accept without emit: load skid and go to FULL.
  - ONE, emit without accept: go to EMPTY.
  - FULL, emit: move skid to main and go to ONE. No accept is possible.
- `in_ready` = (state != FULL), decoded from registered state only.
- `out_valid` = (state != EMPTY).
- `flush` has priority over all other events. The next state is EMPTY, and any same-cycle accept is dropped. A same-cycle emit still completes, because downstream sampled it.
- Reset (`rst_n`=0 at a clock edge) gives:
  - state EMPTY
  - main and skid data 0, error bits 0
  - `out_data`=0, `out_err`=0, `out_valid`=0, `in_ready`=1 from the first cycle after the reset edge
- Reset mid-transfer drops all held entries. There are no partial outputs.
- Data registers hold their value when not loaded. `out_data` is stable while `out_valid & !out_ready`.
- Entries leave in acceptance order; none is duplicated or lost except by flush or reset.

## Timing
- Latency: accept at edge t gives `out_valid`=1 and the data in the cycle after t. One cycle minimum.
- Throughput: one word per cycle when `out_ready` is held at 1.
- `out_ready` falling costs at most one extra accept, absorbed by the skid register. `in_ready` then drops the following cycle.
- After FULL, the first emit raises `in_ready` in the next cycle, giving one-cycle backpressure release.
- No combinational paths from `out_ready` or `flush` to `in_ready`. `in_sel` and `in_data` reach only register D inputs.

## Structure
- Shared package `pds_pkg`:
  - state encoding localparams: EMPTY=2'd0, ONE=2'd1, FULL=2'd2
  - default WIDTH constant
- Sub-module `mux_n_sel` is purely combinational:
  - parameters WIDTH and N
  - input `data` [N*WIDTH-1:0] and `sel`
  - outputs `y` and `err`
  - reusable for the unregistered selects in IF and ID
- Top level: `mux_n_sel` feeding a 3-state controller and the two entry registers.

## Test plan
- Reset, then N=4, WIDTH=32, inputs 0x11111111..0x44444444, sel=2, `out_ready`=1 → next cycle `out_valid`=1, `out_data`=0x33333333, `out_err`=0.
- Streaming: 8 back-to-back accepts with sel cycling 0..3 and `out_ready`=1 → 8 consecutive outputs in order, `in_ready` held 1.
- Backpressure: `out_ready`=0 for 3 cycles while `in_valid`=1 → exactly 2 entries accepted, `in_ready`=0 from the second cycle after the first accept. With `out_ready`=1 the two words drain in order and nothing is lost.
- N=3, sel=3 → `out_data`=0, `out_err`=1. The next entry with sel=1 gives `out_err`=0.
- `flush` in state FULL together with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and neither held entry nor the offered word ever appears.
- `rst_n`=0 for one edge while FULL → all outputs 0, `in_ready`=1 the following cycle. A subsequent accept behaves as from EMPTY.

Source files
------------

// File: rtl/pds_pkg.sv
// rtl/pds_pkg.sv - shared constants for the pipeline data-select blocks
//
// Purpose: holds the state encoding for the skid-buffered select
//          controller and the default data width.
// Contents:
//   PDS_WIDTH    default data width per input
//   pds_state_t  controller state type
//   EMPTY/ONE/FULL  controller state encodings

package pds_pkg;

  localparam int PDS_WIDTH = 32;

  typedef logic [1:0] pds_state_t;

  localparam pds_state_t EMPTY = 2'd0;  // no entry held
  localparam pds_state_t ONE   = 2'd1;  // head entry in main register
  localparam pds_state_t FULL  = 2'd2;  // head in main, next entry in skid

endpackage

// File: rtl/mux_n_sel.sv
// rtl/mux_n_sel.sv - combinational N-way word select with range flag
//
// Purpose: picks word `sel` from a flattened N*WIDTH bus. An index
//          >= N yields word 0 with err raised, so callers never see
//          an arbitrary or X selection.
// Ports:
//   data  in  N*WIDTH  flattened inputs, word k at [k*WIDTH +: WIDTH]
//   sel   in  SELW     word index
//   y     out WIDTH    selected word
//   err   out 1        sel was out of range

module mux_n_sel #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   y,
  output logic               err
);

  // Scan rather than index with sel so an out-of-range select never
  // produces an out-of-bounds part-select.
  always_comb begin
    y   = data[WIDTH-1:0];
    err = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (int'(sel) == k) begin
        y   = data[k*WIDTH +: WIDTH];
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// rtl/mux_pipe_n.sv - registered N-way select with two-entry skid buffer
//
// Purpose: captures the selected input word (plus an out-of-range flag)
//          into a main/skid register pair behind a valid/ready handshake.
//          in_ready and out_valid decode registered state only.
// Ports:
//   clk        in  1        rising-edge clock
//   rst_n      in  1        synchronous active-low reset
//   in_data    in  N*WIDTH  flattened inputs
//   in_sel     in  SELW     index of input to capture
//   in_valid   in  1        upstream offers a word
//   in_ready   out 1        block can accept this cycle
//   flush      in  1        discard all held entries
//   out_data   out WIDTH    head word
//   out_err    out 1        head entry had in_sel >= N
//   out_valid  out 1        head entry present
//   out_ready  in  1        downstream takes the head

module mux_pipe_n
  import pds_pkg::*;
#(
  parameter  int WIDTH = PDS_WIDTH,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  pds_state_t       state_q;
  logic [WIDTH-1:0] main_data_q;
  logic             main_err_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             skid_err_q;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             accept;
  logic             emit;

  mux_n_sel #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_sel (
    .data (in_data),
    .sel  (in_sel),
    .y    (sel_data),
    .err  (sel_err)
  );

  // Pure state decodes: no path from out_ready or flush to in_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_err   = main_err_q;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else if (flush) begin
      // A same-cycle emit was already sampled downstream; any accept is
      // dropped. Data registers keep stale contents, unreachable once EMPTY.
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_q <= sel_data;
            main_err_q  <= sel_err;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_data_q <= sel_data;
            main_err_q  <= sel_err;
          end else if (accept) begin
            // Downstream stalled: park the new word behind the head.
            skid_data_q <= sel_data;
            skid_err_q  <= sel_err;
            state_q     <= FULL;
          end else if (emit) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            main_data_q <= skid_data_q;
            main_err_q  <= skid_err_q;
            state_q     <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_pipe_n.sv
// tb/tb_mux_pipe_n.sv - directed self-checking bench for mux_pipe_n

module tb_mux_pipe_n;

  localparam logic [31:0] W0 = 32'h11111111;
  localparam logic [31:0] W1 = 32'h22222222;
  localparam logic [31:0] W2 = 32'h33333333;
  localparam logic [31:0] W3 = 32'h44444444;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [31:0]  out_data;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  d3_data;
  logic [1:0]   d3_sel;
  logic         d3_valid;
  logic         d3_in_ready;
  logic         d3_flush;
  logic [31:0]  d3_out_data;
  logic         d3_out_err;
  logic         d3_out_valid;
  logic         d3_out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_pipe_n #(.WIDTH(32), .N(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_pipe_n #(.WIDTH(32), .N(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (d3_data),
    .in_sel    (d3_sel),
    .in_valid  (d3_valid),
    .in_ready  (d3_in_ready),
    .flush     (d3_flush),
    .out_data  (d3_out_data),
    .out_err   (d3_out_err),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset out_data: got %h want 0", out_data); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset out_err: got %b want 0", out_err); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_sel = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single out_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== W2) begin n_bad++; $display("FAIL single out_data: got %h want %h", out_data, W2); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL single out_err: got %b want 0", out_err); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single drained out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_w;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel = 2'(i % 4); in_valid = 1'b1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream in_ready[%0d]: got %b want 1", i, in_ready); end
      step();
      exp_w = 32'h11111111 * 32'(i % 4 + 1);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream out_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== exp_w) begin n_bad++; $display("FAIL stream out_data[%0d]: got %h want %h", i, out_data, exp_w); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream end out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp in_ready c1: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== W0) begin n_bad++; $display("FAIL bp out_data c1: got %h want %h", out_data, W0); end
    in_sel = 2'd1;
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp in_ready c2: got %b want 0", in_ready); end
    in_sel = 2'd2;
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp in_ready c3: got %b want 0", in_ready); end
    n_cmp++; if (out_data !== W0) begin n_bad++; $display("FAIL bp hold out_data: got %h want %h", out_data, W0); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp drain out_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== W1) begin n_bad++; $display("FAIL bp drain out_data: got %h want %h", out_data, W1); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp empty out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_err();
    d3_data = {32'hDEADBEEF, 32'h5555AAAA, 32'h00000000};
    d3_sel = 2'd3; d3_valid = 1'b1;
    step();
    n_cmp++; if (d3_out_data !== 32'h0) begin n_bad++; $display("FAIL err oor out_data: got %h want 0", d3_out_data); end
    n_cmp++; if (d3_out_err !== 1'b1) begin n_bad++; $display("FAIL err oor out_err: got %b want 1", d3_out_err); end
    d3_data = {32'hDEADBEEF, 32'h5555AAAA, 32'h0BADF00D};
    d3_sel = 2'd1;
    step();
    n_cmp++; if (d3_out_data !== 32'h5555AAAA) begin n_bad++; $display("FAIL err in-range out_data: got %h want 5555aaaa", d3_out_data); end
    n_cmp++; if (d3_out_err !== 1'b0) begin n_bad++; $display("FAIL err in-range out_err: got %b want 0", d3_out_err); end
    d3_sel = 2'd3;
    step();
    n_cmp++; if (d3_out_data !== 32'h0BADF00D) begin n_bad++; $display("FAIL err word0 out_data: got %h want 0badf00d", d3_out_data); end
    n_cmp++; if (d3_out_err !== 1'b1) begin n_bad++; $display("FAIL err word0 out_err: got %b want 1", d3_out_err); end
    d3_valid = 1'b0;
    step();
    n_cmp++; if (d3_out_valid !== 1'b0) begin n_bad++; $display("FAIL err end out_valid: got %b want 0", d3_out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0;
    step();
    in_sel = 2'd1;
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush full in_ready: got %b want 0", in_ready); end
    flush = 1'b1; in_sel = 2'd2;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush full out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush full in_ready after: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush ghost out_valid[%0d]: got %b want 0", i, out_valid); end
    end
    // Flush in ONE with a same-cycle accept: the offered word is dropped.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    step();
    flush = 1'b1; in_sel = 2'd3;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush one out_valid: got %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush one later out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1;
    step();
    in_sel = 2'd2;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstfull out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rstfull out_data: got %h want 0", out_data); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL rstfull out_err: got %b want 0", out_err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstfull in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd3;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== W3) begin n_bad++; $display("FAIL rstfull next out_data: got %h want %h", out_data, W3); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstfull next out_valid: got %b want 1", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstfull drained out_valid: got %b want 0", out_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = {W3, W2, W1, W0};
    in_sel = 2'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    d3_data = '0; d3_sel = 2'd0; d3_valid = 1'b0; d3_flush = 1'b0; d3_out_ready = 1'b1;
    #1;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_err();
    test_flush();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
